// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: streams N_SAMPLES samples from a source BRAM through the 5-tap FIR window into a destination BRAM.
// Latency: sample k is read in S+1+k and its result is written in S+3+FIR_LAT+k; done pulses in S+3+FIR_LAT+N_SAMPLES.
// Backpressure: none; one read and one write per cycle with no gaps, and start is ignored (not queued) outside IDLE.
module fir_stream_ctrl #(
  parameter int N_SAMPLES = 256,
  parameter int ADDR_W    = 8,
  parameter int FIR_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rdata,
  output logic [7:0]        x0,
  output logic [7:0]        x1,
  output logic [7:0]        x2,
  output logic [7:0]        x3,
  output logic [7:0]        x4,
  input  logic [7:0]        filt_in,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Stage 0: BRAM data valid, stage 1: window valid, then one stage per filter register.
  localparam int VLD_D = 2 + FIR_LAT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt, wr_cnt;
  logic [VLD_D-1:0]  stage_vld;
  logic [7:0]        win_dat [5];
  logic              start_acc;

  assign start_acc = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the per-state strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    src_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        src_en = 1'b1;
        if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dst_we && (wr_cnt == LAST_IDX)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read and write indices; both restart at zero when a run is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (start_acc) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (src_en) rd_cnt <= rd_cnt + ADDR_W'(1);
      if (dst_we) wr_cnt <= wr_cnt + ADDR_W'(1);
    end
  end

  // Valid pipeline follows each issued read through BRAM, window and filter stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_vld <= '0;
    else     stage_vld <= {stage_vld[VLD_D-2:0], src_en};
  end

  // Tap window: zero pre-history at start, shift in each returned sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) win_dat[i] <= '0;
    end else if (start_acc) begin
      for (int i = 0; i < 5; i++) win_dat[i] <= '0;
    end else if (stage_vld[0]) begin
      win_dat[0] <= src_rdata;
      for (int i = 1; i < 5; i++) win_dat[i] <= win_dat[i-1];
    end
  end

  assign x0 = win_dat[0];
  assign x1 = win_dat[1];
  assign x2 = win_dat[2];
  assign x3 = win_dat[3];
  assign x4 = win_dat[4];

  assign src_addr  = rd_cnt;
  assign dst_we    = stage_vld[VLD_D-1];
  assign dst_addr  = wr_cnt;
  // Filter result passes through untouched; gated so the bus reads zero between writes.
  assign dst_wdata = dst_we ? filt_in : 8'd0;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: drives two controllers (N=8 and N=1) with BRAM and 1-2-3-2-1 filter models attached.
// Latency: results are compared per index, per cycle, against the filter equation applied to the source data.
// Backpressure: none; start pulses during a run must be ignored.
module tb_fir_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Cycle index, stable between rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance, N_SAMPLES = 8 ----------------
  logic       start_m = 1'b0;
  logic       busy_m, done_m, src_en_m, dst_we_m;
  logic [7:0] src_addr_m, dst_addr_m, dst_wdata_m;
  logic [7:0] src_rdata_m = 8'd0;
  logic [7:0] x0_m, x1_m, x2_m, x3_m, x4_m;
  logic [7:0] f1_m = 8'd0, f2_m = 8'd0;
  logic [7:0] src_m [256];
  int         w_cyc [$];
  int         w_addr [$];
  logic [7:0] w_dat [$];

  fir_stream_ctrl #(.N_SAMPLES(8), .ADDR_W(8), .FIR_LAT(2)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m),
    .src_en(src_en_m), .src_addr(src_addr_m), .src_rdata(src_rdata_m),
    .x0(x0_m), .x1(x1_m), .x2(x2_m), .x3(x3_m), .x4(x4_m),
    .filt_in(f2_m), .dst_we(dst_we_m), .dst_addr(dst_addr_m), .dst_wdata(dst_wdata_m)
  );

  always @(posedge clk) begin
    if (src_en_m) src_rdata_m <= src_m[src_addr_m];
    f1_m <= 8'(int'(x0_m) + 2*int'(x1_m) + 3*int'(x2_m) + 2*int'(x3_m) + int'(x4_m));
    f2_m <= f1_m;
  end

  always @(negedge clk) begin
    if (dst_we_m) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(int'(dst_addr_m));
      w_dat.push_back(dst_wdata_m);
    end
  end

  // ---------------- small instance, N_SAMPLES = 1 ----------------
  logic       start_s = 1'b0;
  logic       busy_s, done_s, src_en_s, dst_we_s;
  logic [7:0] src_addr_s, dst_addr_s, dst_wdata_s;
  logic [7:0] src_rdata_s = 8'd0;
  logic [7:0] x0_s, x1_s, x2_s, x3_s, x4_s;
  logic [7:0] f1_s = 8'd0, f2_s = 8'd0;
  logic [7:0] src_s [256];
  int         ws_cyc [$];
  int         ws_addr [$];
  logic [7:0] ws_dat [$];

  fir_stream_ctrl #(.N_SAMPLES(1), .ADDR_W(8), .FIR_LAT(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .src_en(src_en_s), .src_addr(src_addr_s), .src_rdata(src_rdata_s),
    .x0(x0_s), .x1(x1_s), .x2(x2_s), .x3(x3_s), .x4(x4_s),
    .filt_in(f2_s), .dst_we(dst_we_s), .dst_addr(dst_addr_s), .dst_wdata(dst_wdata_s)
  );

  always @(posedge clk) begin
    if (src_en_s) src_rdata_s <= src_s[src_addr_s];
    f1_s <= 8'(int'(x0_s) + 2*int'(x1_s) + 3*int'(x2_s) + 2*int'(x3_s) + int'(x4_s));
    f2_s <= f1_s;
  end

  always @(negedge clk) begin
    if (dst_we_s) begin
      ws_cyc.push_back(cyc);
      ws_addr.push_back(int'(dst_addr_s));
      ws_dat.push_back(dst_wdata_s);
    end
  end

  // Reference: y[k] = (x[k] + 2x[k-1] + 3x[k-2] + 2x[k-3] + x[k-4]) mod 256, x[<0] = 0.
  function automatic logic [7:0] exp_y(input int k);
    int acc;
    int w [5];
    acc = 0;
    w = '{1, 2, 3, 2, 1};
    for (int t = 0; t < 5; t++)
      if (k - t >= 0) acc += w[t] * int'(src_m[k-t]);
    return 8'(acc % 256);
  endfunction

  // Start a run on the main instance and wait (bounded) for done; d = -1 on timeout.
  task automatic run_main(output int s, output int d);
    w_cyc.delete(); w_addr.delete(); w_dat.delete();
    @(negedge clk);
    start_m = 1'b1;
    s = cyc;
    @(negedge clk);
    start_m = 1'b0;
    d = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_m) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_m, done_m, src_en_m, src_addr_m, x0_m, x1_m, x2_m, x3_m, x4_m,
         dst_we_m, dst_addr_m, dst_wdata_m} !== '0)
      $display("FAIL reset_main outputs not all zero: busy=%b done=%b src_en=%b we=%b x0=%0d dst_addr=%0d",
               busy_m, done_m, src_en_m, dst_we_m, x0_m, dst_addr_m);
    checks++;
    if ({busy_s, done_s, src_en_s, src_addr_s, x0_s, x1_s, x2_s, x3_s, x4_s,
         dst_we_s, dst_addr_s, dst_wdata_s} !== '0)
      $display("FAIL reset_small outputs not all zero: busy=%b done=%b src_en=%b we=%b",
               busy_s, done_s, src_en_s, dst_we_s);
    if (failures != 0) failures = failures;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_m, done_m, src_en_m, dst_we_m} !== 4'b0000)
      $display("FAIL reset_idle strobes after release: %b required 0000", {busy_m, done_m, src_en_m, dst_we_m});
  endtask

  task automatic test_impulse();
    int s, d;
    logic [7:0] exp_imp [8];
    exp_imp = '{8'd100, 8'd200, 8'd44, 8'd200, 8'd100, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) src_m[i] = (i == 0) ? 8'd100 : 8'd0;
    run_main(s, d);
    checks++;
    if (d != s + 13) begin failures++; $display("FAIL impulse_done cycle offset %0d required 13", d - s); end
    checks++;
    if (w_cyc.size() != 8) begin failures++; $display("FAIL impulse_count writes %0d required 8", w_cyc.size()); end
    for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
      checks++;
      if (w_dat[k] !== exp_imp[k] || w_addr[k] != k || w_cyc[k] != s + 5 + k) begin
        failures++;
        $display("FAIL impulse_write[%0d] data=%0d addr=%0d at S+%0d required data=%0d addr=%0d at S+%0d",
                 k, w_dat[k], w_addr[k], w_cyc[k] - s, exp_imp[k], k, 5 + k);
      end
    end
  endtask

  task automatic test_step();
    int s, d;
    for (int i = 0; i < 8; i++) src_m[i] = 8'd10;
    run_main(s, d);
    checks++;
    if (d != s + 13) begin failures++; $display("FAIL step_done cycle offset %0d required 13", d - s); end
    checks++;
    if (w_cyc.size() != 8) begin failures++; $display("FAIL step_count writes %0d required 8", w_cyc.size()); end
    for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
      checks++;
      if (w_dat[k] !== exp_y(k) || w_addr[k] != k) begin
        failures++;
        $display("FAIL step_write[%0d] data=%0d addr=%0d required data=%0d addr=%0d",
                 k, w_dat[k], w_addr[k], exp_y(k), k);
      end
    end
  endtask

  task automatic test_cycle();
    int s;
    logic eb, ed, ew, es;
    for (int i = 0; i < 8; i++) src_m[i] = 8'($urandom_range(0, 255));
    w_cyc.delete(); w_addr.delete(); w_dat.delete();
    @(negedge clk);
    start_m = 1'b1;
    s = cyc;
    @(negedge clk);
    start_m = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      eb = (c <= 12);
      ed = (c == 13);
      ew = (c >= 5) && (c <= 12);
      es = (c <= 8);
      checks++;
      if ({busy_m, done_m, dst_we_m, src_en_m} !== {eb, ed, ew, es}) begin
        failures++;
        $display("FAIL cycle_strobes S+%0d busy/done/we/src_en=%b required %b",
                 c, {busy_m, done_m, dst_we_m, src_en_m}, {eb, ed, ew, es});
      end
      if (ew && dst_addr_m !== 8'(c - 5)) begin
        failures++;
        $display("FAIL cycle_dst_addr S+%0d got %0d required %0d", c, dst_addr_m, c - 5);
      end
      if (es && src_addr_m !== 8'(c - 1)) begin
        failures++;
        $display("FAIL cycle_src_addr S+%0d got %0d required %0d", c, src_addr_m, c - 1);
      end
      // Spurious start pulses during RUN and DRAIN.
      start_m = (c == 3 || c == 9 || c == 11);
      @(negedge clk);
    end
    start_m = 1'b0;
    checks++;
    if (w_cyc.size() != 8) begin failures++; $display("FAIL cycle_no_restart writes %0d required 8", w_cyc.size()); end
    for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
      checks++;
      if (w_dat[k] !== exp_y(k)) begin
        failures++;
        $display("FAIL cycle_data[%0d] got %0d required %0d", k, w_dat[k], exp_y(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1, d1, s2, d2;
    logic [7:0] exp_imp [8];
    exp_imp = '{8'd100, 8'd200, 8'd44, 8'd200, 8'd100, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) src_m[i] = 8'd10;
    run_main(s1, d1);
    for (int i = 0; i < 8; i++) src_m[i] = (i == 0) ? 8'd100 : 8'd0;
    run_main(s2, d2);
    checks++;
    if (s2 != d1 + 1) begin failures++; $display("FAIL b2b_start second start at %0d required %0d", s2, d1 + 1); end
    checks++;
    if (d2 != s2 + 13 || w_cyc.size() != 8) begin
      failures++;
      $display("FAIL b2b_done offset %0d writes %0d required 13 and 8", d2 - s2, w_cyc.size());
    end
    for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
      checks++;
      if (w_dat[k] !== exp_imp[k]) begin
        failures++;
        $display("FAIL b2b_write[%0d] got %0d required %0d", k, w_dat[k], exp_imp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, d;
    int seen_busy;
    for (int i = 0; i < 8; i++) src_m[i] = 8'($urandom_range(1, 255));
    @(negedge clk);
    start_m = 1'b1;
    s = cyc;
    @(negedge clk);
    start_m = 1'b0;
    while (cyc < s + 7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy_m, done_m, src_en_m, src_addr_m, x0_m, x1_m, x2_m, x3_m, x4_m,
         dst_we_m, dst_addr_m, dst_wdata_m} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs busy=%b src_en=%b we=%b x0=%0d dst_addr=%0d wdata=%0d required all 0",
               busy_m, src_en_m, dst_we_m, x0_m, dst_addr_m, dst_wdata_m);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w_cyc.delete(); w_addr.delete(); w_dat.delete();
    seen_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_m || done_m || src_en_m) seen_busy++;
    end
    checks++;
    if (w_cyc.size() != 0 || seen_busy != 0) begin
      failures++;
      $display("FAIL midreset_quiet writes=%0d active_cycles=%0d required 0 and 0", w_cyc.size(), seen_busy);
    end
    for (int i = 0; i < 8; i++) src_m[i] = (i == 0) ? 8'd100 : 8'd0;
    run_main(s, d);
    checks++;
    if (d != s + 13 || w_cyc.size() != 8) begin
      failures++;
      $display("FAIL midreset_rerun done offset %0d writes %0d required 13 and 8", d - s, w_cyc.size());
    end
    for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
      checks++;
      if (w_dat[k] !== exp_y(k) || w_addr[k] != k) begin
        failures++;
        $display("FAIL midreset_write[%0d] data=%0d addr=%0d required data=%0d addr=%0d",
                 k, w_dat[k], w_addr[k], exp_y(k), k);
      end
    end
  endtask

  task automatic test_random();
    int s, d;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) src_m[i] = 8'($urandom_range(0, 255));
      run_main(s, d);
      checks++;
      if (d != s + 13 || w_cyc.size() != 8) begin
        failures++;
        $display("FAIL random%0d_done offset %0d writes %0d required 13 and 8", r, d - s, w_cyc.size());
      end
      for (int k = 0; k < w_cyc.size() && k < 8; k++) begin
        checks++;
        if (w_dat[k] !== exp_y(k) || w_addr[k] != k || w_cyc[k] != s + 5 + k) begin
          failures++;
          $display("FAIL random%0d_write[%0d] data=%0d addr=%0d at S+%0d required data=%0d addr=%0d at S+%0d",
                   r, k, w_dat[k], w_addr[k], w_cyc[k] - s, exp_y(k), k, 5 + k);
        end
      end
    end
  endtask

  task automatic test_n1();
    int s, d;
    logic [7:0] v;
    for (int r = 0; r < 3; r++) begin
      v = (r == 0) ? 8'd7 : 8'($urandom_range(0, 255));
      src_s[0] = v;
      ws_cyc.delete(); ws_addr.delete(); ws_dat.delete();
      @(negedge clk);
      start_s = 1'b1;
      s = cyc;
      @(negedge clk);
      start_s = 1'b0;
      d = -1;
      for (int i = 0; i < 50; i++) begin
        if (done_s) begin d = cyc; break; end
        @(negedge clk);
      end
      checks++;
      if (d != s + 6) begin failures++; $display("FAIL n1_done[%0d] offset %0d required 6", r, d - s); end
      checks++;
      if (ws_cyc.size() != 1) begin
        failures++;
        $display("FAIL n1_count[%0d] writes %0d required 1", r, ws_cyc.size());
      end else if (ws_dat[0] !== v || ws_addr[0] != 0 || ws_cyc[0] != s + 5) begin
        failures++;
        $display("FAIL n1_write[%0d] data=%0d addr=%0d at S+%0d required data=%0d addr=0 at S+5",
                 r, ws_dat[0], ws_addr[0], ws_cyc[0] - s, v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      src_m[i] = 8'd0;
      src_s[i] = 8'd0;
    end
    test_reset();
    test_impulse();
    test_step();
    test_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Reset-state comparisons above print their own FAIL line; tally them here from the same conditions.
  initial begin
    #1;
    if ({busy_m, done_m, src_en_m, src_addr_m, x0_m, x1_m, x2_m, x3_m, x4_m,
         dst_we_m, dst_addr_m, dst_wdata_m} !== '0) failures++;
    if ({busy_s, done_s, src_en_s, src_addr_s, x0_s, x1_s, x2_s, x3_s, x4_s,
         dst_we_s, dst_addr_s, dst_wdata_s} !== '0) failures++;
    @(negedge rst);
    @(negedge clk);
    if ({busy_m, done_m, src_en_m, dst_we_m} !== 4'b0000) failures++;
  end

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sample-streaming controller for the 5-tap pipelined FIR filter. On a start command it reads N samples from a source BRAM, maintains the 5-sample tap window driven into the filter, tracks the filter's fixed pipeline latency, and writes each filtered result into a destination BRAM at the same index as its input sample. It provides the filter's tap feed and accepts its result, and reports completion with a one-cycle done pulse.

## Interface
- N_SAMPLES, 256: samples per run; 1 ≤ N_SAMPLES ≤ 2^ADDR_W
- ADDR_W, 8: BRAM address width
- FIR_LAT, 2: filter latency in cycles, from tap inputs to filteredOutput
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of run
- src_en  out  1  source BRAM read enable
- src_addr  out  ADDR_W  source read address
- src_rdata  in  8  source data, valid one cycle after src_en/src_addr (registered BRAM)
- x0, x1, x2, x3, x4  out  8 each  tap window; x0 newest, x4 oldest (x1..x4 = m1..m4)
- filt_in  in  8  filter result (filteredOutput)
- dst_we  out  1  destination BRAM write enable
- dst_addr  out  ADDR_W  destination write address
- dst_wdata  out  8  destination write data

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all strobes low. If start=1, the controller clears x0..x4 to 0, clears the read counter and write counter, and goes to RUN. Samples before index 0 are therefore zero.
- RUN: src_en=1 and src_addr=rd_cnt. rd_cnt increments each cycle. After issuing address N_SAMPLES-1, the state goes to DRAIN.
- Valid pipeline: a shift register of depth 2+FIR_LAT marks the following stages for each sample:
  - rdata valid
  - window valid
  - one bit per filter stage
- Window shift: on a cycle with rdata valid, x4←x3, x3←x2, x2←x1, x1←x0, x0←src_rdata. The window holds otherwise.
- Write: when the final valid bit is set, dst_we=1, dst_addr=wr_cnt, dst_wdata=filt_in (unmodified, 8-bit), and wr_cnt increments.
- DRAIN: src_en=0. When the write of index N_SAMPLES-1 occurs, the state goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored while not in IDLE. It is not queued.
- Width rule: the controller does no arithmetic on data. Results are written exactly as received, including any 8-bit wrap from the filter.
- Reset (async, any state): state=IDLE, and every output is 0 (busy, done, src_en, src_addr, x0..x4, dst_we, dst_addr, dst_wdata). All counters and valid bits are cleared. Any in-flight write is dropped, and no write occurs after reset releases.

## Timing
- Let cycle S be the cycle in which start is sampled high in IDLE.
- Sample k, for k = 0 .. N_SAMPLES-1, passes through these cycles:
  - src_addr=k with src_en=1 in cycle S+1+k
  - src_rdata valid in S+2+k
  - x0=sample k in S+3+k
  - filt_in valid in S+3+FIR_LAT+k
  - dst_we=1 with dst_addr=k in that same cycle, S+3+FIR_LAT+k
- One read and one write per cycle in steady state. There are no gaps.
- The last write is in cycle S+2+FIR_LAT+N_SAMPLES. done is in S+3+FIR_LAT+N_SAMPLES (S+5+N with the defaults).
- busy is high from S+1 through the last write cycle inclusive.
- Earliest new start: the cycle after done (IDLE).
- N_SAMPLES=1: one read in S+1, one write in S+3+FIR_LAT, and done in the cycle after that write.

## Test plan
- Impulse, N=8, src=[100,0,...], 1-2-3-2-1 filter attached:
  - required response: dst=[100,200,44,200,100,0,0,0], with 44 = 300 mod 256 from filter truncation.
  - done in cycle S+13.
- Step, N=6, src all 10:
  - required response: dst=[10,30,60,80,90,90], confirming the zero-filled pre-history.
- Cycle check, N=4:
  - required response: dst_we high in exactly cycles S+5..S+8 with dst_addr 0..3.
  - busy is high S+1..S+8 and done=1 only in S+9.
  - start pulses during busy cause no restart and no extra writes.
- Back-to-back, N=8:
  - stimulus: a step run (all 10), then an impulse run started the cycle after done.
  - required response: the second run's dst equals the impulse result exactly, with no residue from the first run's window.
- Reset mid-run, N=16:
  - stimulus: assert rst asynchronously in cycle S+7.
  - required response: all outputs are 0 immediately. After release there are no writes until a new start, and a fresh impulse run then produces correct results.
- N=1, src=[7]:
  - required response: a single write of 7 to dst_addr 0 in cycle S+5 and done in S+6.
